// File: rtl/sparrow_pkg.sv
`default_nettype none
// ============================================================================
// sparrow_pkg : shared types and constants for the sparrow core memory path
// Revision    : 1.0
// ============================================================================
package sparrow_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_WAIT_GNT = 2'd1,
        ARB_WAIT_RSP = 2'd2
    } mem_arb_state_e;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } mem_arb_owner_e;

    localparam logic [1:0] MEM_BYTE_EN_WORD = 2'b10;

endpackage
`default_nettype wire

// File: rtl/sparrow_mem_arbiter.sv
`default_nettype none
// ============================================================================
// sparrow_mem_arbiter : shares one single-port memory bus between the fetch
//                       and data ports, one transaction outstanding at a time
// Revision            : 1.0
// ============================================================================
module sparrow_mem_arbiter
    import sparrow_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        imem_req_i,
    input  logic [31:0] imem_addr_i,
    output logic [31:0] imem_rdata_o,
    output logic        imem_valid_o,
    input  logic        dmem_req_i,
    input  logic [31:0] dmem_addr_i,
    input  logic [1:0]  dmem_byte_en_i,
    input  logic        dmem_wr_i,
    input  logic [31:0] dmem_wr_data_i,
    output logic [31:0] dmem_rdata_o,
    output logic        dmem_valid_o,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    output logic [31:0] mem_addr_o,
    output logic [1:0]  mem_byte_en_o,
    output logic        mem_wr_o,
    output logic [31:0] mem_wr_data_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        stall_o
);

    localparam int unsigned STREAK_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);
    localparam logic LIMIT_ON = (STARVE_LIMIT != 0);

    mem_arb_state_e      state;
    mem_arb_state_e      state_next;
    mem_arb_owner_e      owner;
    logic [STREAK_W-1:0] streak;
    logic                i_elig;
    logic                d_elig;
    logic                starved;
    logic                pick_i;
    logic                pick_d;
    logic                gnt_fire;
    logic                rsp_fire;

    always_comb begin
        i_elig     = imem_req_i & ~imem_valid_o;
        d_elig     = dmem_req_i & ~dmem_valid_o;
        starved    = LIMIT_ON & (streak == STREAK_MAX);
        pick_i     = 1'b0;
        pick_d     = 1'b0;
        gnt_fire   = 1'b0;
        rsp_fire   = 1'b0;
        state_next = state;
        case (state)
            ARB_IDLE: begin
                // Data wins ties unless the fetch port has waited out its streak.
                if (d_elig && !(i_elig && starved)) begin
                    pick_d = 1'b1;
                end else if (i_elig) begin
                    pick_i = 1'b1;
                end
                if (pick_d || pick_i) begin
                    state_next = ARB_WAIT_GNT;
                end
            end
            ARB_WAIT_GNT: begin
                gnt_fire = mem_gnt_i;
                if (mem_gnt_i) begin
                    state_next = ARB_WAIT_RSP;
                end
            end
            ARB_WAIT_RSP: begin
                rsp_fire = mem_rvalid_i;
                if (mem_rvalid_i) begin
                    state_next = ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner         <= OWNER_I;
            streak        <= '0;
            mem_req_o     <= 1'b0;
            mem_addr_o    <= 32'd0;
            mem_byte_en_o <= 2'b00;
            mem_wr_o      <= 1'b0;
            mem_wr_data_o <= 32'd0;
            imem_valid_o  <= 1'b0;
            dmem_valid_o  <= 1'b0;
            imem_rdata_o  <= 32'd0;
            dmem_rdata_o  <= 32'd0;
        end else begin
            imem_valid_o <= 1'b0;
            dmem_valid_o <= 1'b0;
            if (pick_d) begin
                owner         <= OWNER_D;
                mem_req_o     <= 1'b1;
                mem_addr_o    <= dmem_addr_i;
                mem_byte_en_o <= dmem_byte_en_i;
                mem_wr_o      <= dmem_wr_i;
                mem_wr_data_o <= dmem_wr_data_i;
                if (!i_elig) begin
                    streak <= '0;
                end else if (streak != STREAK_MAX) begin
                    streak <= streak + STREAK_W'(1);
                end
            end else if (pick_i) begin
                owner         <= OWNER_I;
                mem_req_o     <= 1'b1;
                mem_addr_o    <= imem_addr_i;
                mem_byte_en_o <= MEM_BYTE_EN_WORD;
                mem_wr_o      <= 1'b0;
                mem_wr_data_o <= 32'd0;
                streak        <= '0;
            end
            if (gnt_fire) begin
                mem_req_o <= 1'b0;
            end
            if (rsp_fire) begin
                if (owner == OWNER_D) begin
                    dmem_rdata_o <= mem_rdata_i;
                    dmem_valid_o <= 1'b1;
                end else begin
                    imem_rdata_o <= mem_rdata_i;
                    imem_valid_o <= 1'b1;
                end
            end
        end
    end

    assign stall_o = reset_n & ((imem_req_i & ~imem_valid_o) | (dmem_req_i & ~dmem_valid_o));

endmodule
`default_nettype wire
